// File: rtl/octo_uart_arbiter_pkg.sv
// Shared definitions for the octo_manager -> serial_transmitter arbiter.
// The frame width is shared with octo_manager and serial_transmitter.
package octo_uart_arbiter_pkg;

  localparam int unsigned FRAME_W = 272;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DROP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/octo_uart_arbiter_if.sv
// Bus between the octo_managers, the arbiter and the serial_transmitter.
// slave is the arbiter side; master is the requester/transmitter side.
interface octo_uart_arbiter_if #(
  parameter int unsigned NUM_OCTO = 4,
  parameter int unsigned FRAME_W  = octo_uart_arbiter_pkg::FRAME_W,
  parameter int unsigned ID_W     = 2
);

  logic [NUM_OCTO-1:0]         data_avl_in;
  logic [NUM_OCTO*FRAME_W-1:0] sensor_iterations_in;
  logic                        tx_done;
  logic                        data_avl_out;
  logic [FRAME_W-1:0]          sensor_iterations_out;
  logic [ID_W-1:0]             octo_id_out;
  logic [NUM_OCTO-1:0]         reset_parser_out;
  logic [NUM_OCTO-1:0]         grant;
  logic                        timeout_err;

  modport slave (
    input  data_avl_in, sensor_iterations_in, tx_done,
    output data_avl_out, sensor_iterations_out, octo_id_out,
           reset_parser_out, grant, timeout_err
  );

  modport master (
    output data_avl_in, sensor_iterations_in, tx_done,
    input  data_avl_out, sensor_iterations_out, octo_id_out,
           reset_parser_out, grant, timeout_err
  );

endinterface

// File: rtl/octo_uart_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping around, returned as one-hot grant and binary index.
module rr_priority_picker #(
  parameter int unsigned NUM_OCTO = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic [NUM_OCTO-1:0] i_req,
  input  logic [ID_W-1:0]     i_ptr,
  output logic [NUM_OCTO-1:0] o_grant_c,
  output logic [ID_W-1:0]     o_idx_c,
  output logic                o_valid_c
);

  // Lowest set bit overall is the wrap fallback; lowest at/after ptr overrides it.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int k = NUM_OCTO - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_grant_c    = '0;
        o_grant_c[k] = 1'b1;
        o_idx_c      = ID_W'(k);
        o_valid_c    = 1'b1;
      end
    end
    for (int k = NUM_OCTO - 1; k >= 0; k--) begin
      if (i_req[k] && (k >= int'(i_ptr))) begin
        o_grant_c    = '0;
        o_grant_c[k] = 1'b1;
        o_idx_c      = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/octo_uart_arbiter.sv
// Round-robin sharing of one serial_transmitter between NUM_OCTO octo_managers,
// running in the clk_12MHz domain with synchronized data_avl requests.
module octo_uart_arbiter #(
  parameter int unsigned NUM_OCTO     = 4,
  parameter int unsigned FRAME_W      = octo_uart_arbiter_pkg::FRAME_W,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned DROP_TIMEOUT = 255
) (
  input  logic                clk_12MHz,
  input  logic                reset_n,
  octo_uart_arbiter_if.slave  bus
);

  import octo_uart_arbiter_pkg::*;

  localparam int unsigned CNT_W = $clog2(DROP_TIMEOUT + 1);

  arb_state_e          r_state, w_state_nxt;
  logic [NUM_OCTO-1:0] r_sync1, r_req_s, r_stale, w_stale_nxt;
  logic [NUM_OCTO-1:0] r_grant, w_grant_nxt, r_reset_parser, w_reset_parser_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt, r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_data_avl, w_data_avl_nxt, r_timeout, w_timeout_nxt;
  logic [FRAME_W-1:0]  r_frame, w_frame_nxt;

  logic [FRAME_W-1:0]  w_frames [NUM_OCTO];
  logic [NUM_OCTO-1:0] w_req_elig, w_pick_grant;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_valid;

  for (genvar k = 0; k < NUM_OCTO; k++) begin : gen_frames
    assign w_frames[k] = bus.sensor_iterations_in[k*FRAME_W +: FRAME_W];
  end

  // Requesters that timed out stay masked until their data_avl drops.
  assign w_req_elig = r_req_s & ~r_stale;

  rr_priority_picker #(
    .NUM_OCTO (NUM_OCTO),
    .ID_W     (ID_W)
  ) u_picker (
    .i_req     (w_req_elig),
    .i_ptr     (r_ptr),
    .o_grant_c (w_pick_grant),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_req_s <= '0;
    end else begin
      r_sync1 <= bus.data_avl_in;
      r_req_s <= r_sync1;
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_stale        <= '0;
      r_grant        <= '0;
      r_reset_parser <= '0;
      r_ptr          <= '0;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_data_avl     <= 1'b0;
      r_timeout      <= 1'b0;
      r_frame        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_stale        <= w_stale_nxt;
      r_grant        <= w_grant_nxt;
      r_reset_parser <= w_reset_parser_nxt;
      r_ptr          <= w_ptr_nxt;
      r_idx          <= w_idx_nxt;
      r_cnt          <= w_cnt_nxt;
      r_data_avl     <= w_data_avl_nxt;
      r_timeout      <= w_timeout_nxt;
      r_frame        <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_stale_nxt        = r_stale & r_req_s;
    w_grant_nxt        = r_grant;
    w_reset_parser_nxt = '0;
    w_ptr_nxt          = r_ptr;
    w_idx_nxt          = r_idx;
    w_cnt_nxt          = r_cnt;
    w_data_avl_nxt     = r_data_avl;
    w_timeout_nxt      = 1'b0;
    w_frame_nxt        = r_frame;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt    = SEND;
          w_idx_nxt      = w_pick_idx;
          w_grant_nxt    = w_pick_grant;
          w_frame_nxt    = w_frames[w_pick_idx];
          w_data_avl_nxt = 1'b1;
        end
      end
      SEND: begin
        if (bus.tx_done) begin
          w_state_nxt        = WAIT_DROP;
          w_data_avl_nxt     = 1'b0;
          w_reset_parser_nxt = r_grant;
          w_ptr_nxt          = (r_idx == ID_W'(NUM_OCTO - 1)) ? '0 : r_idx + 1'b1;
          w_cnt_nxt          = '0;
        end
      end
      WAIT_DROP: begin
        // Hold ownership until the released requester withdraws its stale request.
        if ((r_req_s & r_grant) == '0) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end else if (r_cnt == CNT_W'(DROP_TIMEOUT - 1)) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
          w_stale_nxt   = (r_stale & r_req_s) | r_grant;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.data_avl_out          = r_data_avl;
  assign bus.sensor_iterations_out = r_frame;
  assign bus.octo_id_out           = r_idx;
  assign bus.reset_parser_out      = r_reset_parser;
  assign bus.grant                 = r_grant;
  assign bus.timeout_err           = r_timeout;

endmodule

// File: tb/tb_octo_uart_arbiter.sv
// Self-checking bench for octo_uart_arbiter: scoreboard of expected frames
// plus per-scenario inline checks of handshake, fairness, timeout and reset.
module tb_octo_uart_arbiter;

  localparam int unsigned NUM_OCTO     = 4;
  localparam int unsigned FRAME_W      = 272;
  localparam int unsigned ID_W         = 2;
  localparam int unsigned DROP_TIMEOUT = 255;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [FRAME_W-1:0] frame;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  octo_uart_arbiter_if #(.NUM_OCTO(NUM_OCTO), .FRAME_W(FRAME_W), .ID_W(ID_W)) bus ();

  octo_uart_arbiter #(
    .NUM_OCTO     (NUM_OCTO),
    .FRAME_W      (FRAME_W),
    .ID_W         (ID_W),
    .DROP_TIMEOUT (DROP_TIMEOUT)
  ) dut (
    .clk_12MHz (clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_avl = 1'b0;

  function automatic logic [FRAME_W-1:0] mk_frame(int k);
    logic [15:0] w;
    w = 16'hA5A0 | 16'(k);
    return {17{w}};
  endfunction

  function automatic void push_exp(int id);
    exp_t e;
    e.id    = ID_W'(id);
    e.frame = mk_frame(id);
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every new frame offered to the transmitter is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && bus.data_avl_out === 1'b1 && prev_avl !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_frame: id=%0d offered, none expected", bus.octo_id_out);
      end else begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if (bus.octo_id_out !== mon_e.id) begin
          n_err++;
          $display("FAIL sb_id: got %0d required %0d", bus.octo_id_out, mon_e.id);
        end
        n_cmp++;
        if (bus.sensor_iterations_out !== mon_e.frame) begin
          n_err++;
          $display("FAIL sb_frame: got %h required %h", bus.sensor_iterations_out, mon_e.frame);
        end
        n_cmp++;
        if (bus.grant !== NUM_OCTO'(1 << mon_e.id)) begin
          n_err++;
          $display("FAIL sb_grant: got %b required %b", bus.grant, NUM_OCTO'(1 << mon_e.id));
        end
      end
    end
    prev_avl = bus.data_avl_out;
  end

  task automatic wait_avl(string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.data_avl_out === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_avl_wait: data_avl_out=%b required 1 within 40 cycles", tag, bus.data_avl_out);
    end
  endtask

  // Complete the current frame for requester g, release it, and wait for grant to drop.
  task automatic serve(int g, string tag);
    bit dropped = 1'b0;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    n_cmp++;
    if (bus.reset_parser_out !== NUM_OCTO'(1 << g)) begin
      n_err++;
      $display("FAIL %s_reset_parser: got %b required %b", tag, bus.reset_parser_out, NUM_OCTO'(1 << g));
    end
    n_cmp++;
    if (bus.data_avl_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s_avl_clear: got %b required 0", tag, bus.data_avl_out);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.reset_parser_out !== '0) begin
      n_err++;
      $display("FAIL %s_reset_parser_width: got %b required 0", tag, bus.reset_parser_out);
    end
    bus.data_avl_in[g] = 1'b0;
    for (int i = 0; i < 8 && !dropped; i++) begin
      @(negedge clk);
      if (bus.grant === '0) dropped = 1'b1;
    end
    n_cmp++;
    if (!dropped) begin
      n_err++;
      $display("FAIL %s_grant_release: grant=%b required 0 within 8 cycles", tag, bus.grant);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.data_avl_in          = '0;
    bus.tx_done              = 1'b0;
    for (int k = 0; k < NUM_OCTO; k++)
      bus.sensor_iterations_in[k*FRAME_W +: FRAME_W] = mk_frame(k);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.data_avl_out, bus.octo_id_out, bus.reset_parser_out, bus.grant, bus.timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: avl=%b id=%0d rp=%b grant=%b to=%b required all 0",
               bus.data_avl_out, bus.octo_id_out, bus.reset_parser_out, bus.grant, bus.timeout_err);
    end
    n_cmp++;
    if (bus.sensor_iterations_out !== '0) begin
      n_err++;
      $display("FAIL reset_frame: got %h required 0", bus.sensor_iterations_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bus.data_avl_in = 4'b0010;
    push_exp(1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.data_avl_out !== 1'b0) begin
      n_err++;
      $display("FAIL single_early: data_avl_out=%b required 0 after 2 cycles", bus.data_avl_out);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.data_avl_out !== 1'b1 || bus.octo_id_out !== 2'd1) begin
      n_err++;
      $display("FAIL single_latency: avl=%b id=%0d required avl=1 id=1 after 3 cycles",
               bus.data_avl_out, bus.octo_id_out);
    end
    serve(1, "single");
  endtask

  task automatic test_all_four();
    apply_reset();
    bus.data_avl_in = 4'b1111;
    for (int g = 0; g < NUM_OCTO; g++) push_exp(g);
    for (int g = 0; g < NUM_OCTO; g++) begin
      wait_avl("all4");
      serve(g, "all4");
    end
  endtask

  task automatic test_rr_fairness();
    bus.data_avl_in[2] = 1'b1;
    push_exp(2);
    wait_avl("rr");
    bus.data_avl_in[0] = 1'b1;
    bus.data_avl_in[3] = 1'b1;
    push_exp(3);
    push_exp(0);
    serve(2, "rr2");
    wait_avl("rr");
    n_cmp++;
    if (bus.octo_id_out !== 2'd3) begin
      n_err++;
      $display("FAIL rr_order: got id %0d required 3", bus.octo_id_out);
    end
    serve(3, "rr3");
    wait_avl("rr");
    serve(0, "rr0");
  endtask

  task automatic test_stuck();
    int to_at = -1;
    int to_cnt = 0;
    int rp_cnt = 0;
    int avl_cnt = 0;
    logic [NUM_OCTO-1:0] grant_at_to = '1;
    bus.data_avl_in[0] = 1'b1;
    push_exp(0);
    wait_avl("stuck");
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    n_cmp++;
    if (bus.reset_parser_out !== 4'b0001) begin
      n_err++;
      $display("FAIL stuck_reset_parser: got %b required 0001", bus.reset_parser_out);
    end
    for (int c = 1; c <= int'(DROP_TIMEOUT) + 3; c++) begin
      @(negedge clk);
      if (bus.timeout_err === 1'b1) begin
        to_cnt++;
        if (to_at < 0) begin
          to_at = c;
          grant_at_to = bus.grant;
        end
      end
      if (bus.reset_parser_out !== '0) rp_cnt++;
    end
    n_cmp++;
    if (to_at != int'(DROP_TIMEOUT) || to_cnt != 1) begin
      n_err++;
      $display("FAIL stuck_timeout: first at cycle %0d width %0d required cycle %0d width 1",
               to_at, to_cnt, DROP_TIMEOUT);
    end
    n_cmp++;
    if (grant_at_to !== '0) begin
      n_err++;
      $display("FAIL stuck_grant: got %b at timeout required 0", grant_at_to);
    end
    n_cmp++;
    if (rp_cnt != 0) begin
      n_err++;
      $display("FAIL stuck_repulse: %0d reset_parser cycles required 0", rp_cnt);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.data_avl_out === 1'b1) avl_cnt++;
    end
    n_cmp++;
    if (avl_cnt != 0) begin
      n_err++;
      $display("FAIL stuck_resend: data_avl_out high %0d cycles required 0", avl_cnt);
    end
    bus.data_avl_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus.data_avl_in[0] = 1'b1;
    push_exp(0);
    wait_avl("stuck_rerise");
    serve(0, "stuck_rerise");
  endtask

  task automatic test_spurious_tx_done();
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    n_cmp++;
    if (bus.reset_parser_out !== '0 || bus.data_avl_out !== 1'b0 || bus.grant !== '0) begin
      n_err++;
      $display("FAIL spurious_tx_done: rp=%b avl=%b grant=%b required 0/0/0",
               bus.reset_parser_out, bus.data_avl_out, bus.grant);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.reset_parser_out !== '0 || bus.data_avl_out !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_tx_done_late: rp=%b avl=%b required 0/0",
               bus.reset_parser_out, bus.data_avl_out);
    end
  endtask

  task automatic test_reset_mid_send();
    bus.data_avl_in = 4'b0101;
    push_exp(2);
    wait_avl("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_avl_out, bus.octo_id_out, bus.reset_parser_out, bus.grant, bus.timeout_err} !== '0 ||
        bus.sensor_iterations_out !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async: avl=%b id=%0d rp=%b grant=%b required all 0",
               bus.data_avl_out, bus.octo_id_out, bus.reset_parser_out, bus.grant);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    push_exp(0);
    push_exp(2);
    wait_avl("rst_mid_a");
    serve(0, "rst_mid_a");
    wait_avl("rst_mid_b");
    serve(2, "rst_mid_b");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: %0d expected frames never offered, required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_fairness();
    test_stuck();
    test_spurious_tx_done();
    test_reset_mid_send();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
